// File: rtl/nvram_backup_ctrl.sv
// Save-RAM sector sequencer between the backup dpram (port B) and a mounted SD image.
// Optional idle autosave is built when NVRAM_AUTOSAVE_EN is defined.
module nvram_backup_ctrl #(
    parameter int SECT_LOG2    = 4,
    parameter int LBA_W        = 32,
    parameter int AUTOSAVE_DLY = 22
) (
    input  logic                 clk_sys,
    input  logic                 RESET_n,
    input  logic                 img_mounted,
    input  logic [31:0]          img_size,
    input  logic                 ioctl_download,
    input  logic                 save_req,
    input  logic                 core_we,
    output logic [LBA_W-1:0]     sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [8:0]           sd_buff_addr,
    input  logic                 sd_buff_wr,
    output logic [SECT_LOG2+8:0] buf_a,
    output logic                 buf_we,
    output logic                 bk_ena,
    output logic                 bk_reset,
    output logic                 busy,
    output logic                 dirty
);

    localparam int CNT_W = SECT_LOG2 + 1;
    localparam logic [CNT_W-1:0] MAX_SECT = {1'b1, {SECT_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SAVE,
        ABORT
    } state_t;

    state_t               state_q, state_d;
    logic [SECT_LOG2-1:0] lba_q, lba_d;
    logic [CNT_W-1:0]     n_sect_q, n_sect_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 dirty_q, dirty_d;
    logic                 bk_ena_q, bk_ena_d;
    logic                 pend_q, pend_d;
    logic                 bk_reset_q, bk_reset_d;

    logic                 mounted_q, save_q, download_q, ack_q;
    logic                 mount_rise, save_rise, dl_rise, ack_rise, ack_fall;
    logic                 save_go, auto_req, last_sect;
    logic [23:0]          raw_sect;
    logic [CNT_W-1:0]     mount_sect;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            mounted_q  <= 1'b0;
            save_q     <= 1'b0;
            download_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            mounted_q  <= img_mounted;
            save_q     <= save_req;
            download_q <= ioctl_download;
            ack_q      <= sd_ack;
        end
    end

    assign mount_rise = img_mounted & ~mounted_q;
    assign save_rise  = save_req & ~save_q;
    assign dl_rise    = ioctl_download & ~download_q;
    assign ack_rise   = sd_ack & ~ack_q;
    assign ack_fall   = ~sd_ack & ack_q;

    // Sector count rounds a partial trailing sector up, then clamps to the RAM size.
    assign raw_sect   = {1'b0, img_size[31:9]} + {23'd0, |img_size[8:0]};
    assign mount_sect = (raw_sect > {{(24-CNT_W){1'b0}}, MAX_SECT}) ? MAX_SECT : raw_sect[CNT_W-1:0];

    assign last_sect  = ({1'b0, lba_q} == (n_sect_q - {{(CNT_W-1){1'b0}}, 1'b1}));

`ifdef NVRAM_AUTOSAVE_EN
    logic [AUTOSAVE_DLY-1:0] idle_cnt;
    logic                    auto_q;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            idle_cnt <= '0;
            auto_q   <= 1'b0;
        end else begin
            auto_q <= 1'b0;
            if (!(bk_ena_q && dirty_q && !busy_q) || core_we) begin
                idle_cnt <= '0;
            end else if (&idle_cnt) begin
                idle_cnt <= '0;
                auto_q   <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign auto_req = auto_q;
`else
    assign auto_req = 1'b0;
`endif

    assign save_go = save_rise | auto_req;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        n_sect_d   = n_sect_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        dirty_d    = dirty_q;
        bk_ena_d   = bk_ena_q;
        pend_d     = pend_q;
        bk_reset_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A mount in the same cycle as a save request wins; the save is dropped.
                if (bk_ena_q && pend_q && !dl_rise) begin
                    state_d = LOAD;
                    lba_d   = '0;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (bk_ena_q && save_go && !mount_rise && !dl_rise) begin
                    state_d = SAVE;
                    lba_d   = '0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LOAD, SAVE: begin
                if (dl_rise) begin
                    state_d = ABORT;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    if (ack_rise) begin
                        rd_d = 1'b0;
                        wr_d = 1'b0;
                    end
                    if (ack_fall) begin
                        if (last_sect) begin
                            state_d    = IDLE;
                            busy_d     = 1'b0;
                            dirty_d    = 1'b0;
                            pend_d     = 1'b0;
                            bk_reset_d = (state_q == LOAD);
                        end else begin
                            lba_d = lba_q + 1'b1;
                            rd_d  = (state_q == LOAD);
                            wr_d  = (state_q == SAVE);
                        end
                    end
                end
            end
            ABORT: begin
                if (!sd_ack) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mount_rise) begin
            if (img_size != 32'd0) begin
                bk_ena_d = 1'b1;
                n_sect_d = mount_sect;
                pend_d   = 1'b1;
            end else begin
                bk_ena_d = 1'b0;
                pend_d   = 1'b0;
            end
        end

        if (dl_rise) begin
            bk_ena_d = 1'b0;
            pend_d   = 1'b0;
        end

        if (core_we) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            lba_q      <= '0;
            n_sect_q   <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            dirty_q    <= 1'b0;
            bk_ena_q   <= 1'b0;
            pend_q     <= 1'b0;
            bk_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            n_sect_q   <= n_sect_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            dirty_q    <= dirty_d;
            bk_ena_q   <= bk_ena_d;
            pend_q     <= pend_d;
            bk_reset_q <= bk_reset_d;
        end
    end

    assign sd_lba   = {{(LBA_W-SECT_LOG2){1'b0}}, lba_q};
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign buf_a    = {lba_q, sd_buff_addr};
    assign buf_we   = sd_buff_wr & sd_ack & (state_q == LOAD);
    assign bk_ena   = bk_ena_q;
    assign bk_reset = bk_reset_q;
    assign busy     = busy_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Directed bench for nvram_backup_ctrl: load, save, clamp, buffer port, abort, priority, reset.
module tb_nvram_backup_ctrl;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        img_mounted;
    logic [31:0] img_size;
    logic        ioctl_download;
    logic        save_req;
    logic        core_we;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [12:0] buf_a;
    logic        buf_we;
    logic        bk_ena;
    logic        bk_reset;
    logic        busy;
    logic        dirty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    nvram_backup_ctrl dut (
        .clk_sys        (clk_sys),
        .RESET_n        (RESET_n),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .ioctl_download (ioctl_download),
        .save_req       (save_req),
        .core_we        (core_we),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_buff_wr     (sd_buff_wr),
        .buf_a          (buf_a),
        .buf_we         (buf_we),
        .bk_ena         (bk_ena),
        .bk_reset       (bk_reset),
        .busy           (busy),
        .dirty          (dirty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a request; reports a timeout as a failed comparison.
    task automatic wait_req(output bit ok);
        int n = 0;
        @(negedge clk_sys);
        while (!(sd_rd || sd_wr) && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        ok = sd_rd || sd_wr;
        if (!ok) check("req_timeout", 32'(sd_rd | sd_wr), 32'd1);
    endtask

    // Plays user_io for one sector: checks the request, acks it, optionally probes the buffer port.
    task automatic serve(input bit is_wr, input int lba, input bit probe, input bit exp_we,
                         input bit we_at_fall);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("req_kind", {30'd0, sd_rd, sd_wr}, is_wr ? 32'd1 : 32'd2);
        check("req_lba", sd_lba, 32'(lba));
        @(posedge clk_sys);
        #1;
        sd_ack = 1'b1;
        if (probe) begin
            sd_buff_addr = 9'd5;
            sd_buff_wr   = 1'b1;
        end
        @(negedge clk_sys);
        if (probe) begin
            check("buf_a", 32'(buf_a), (32'(lba) << 9) | 32'd5);
            check("buf_we", 32'(buf_we), 32'(exp_we));
        end
        @(negedge clk_sys);
        check("req_clear", {30'd0, sd_rd, sd_wr}, 32'd0);
        @(posedge clk_sys);
        #1;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        core_we    = we_at_fall;
        @(posedge clk_sys);
        #1;
        core_we = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        bit ok;
        bit seen;

        RESET_n        = 1'b0;
        img_mounted    = 1'b0;
        img_size       = 32'd0;
        ioctl_download = 1'b0;
        save_req       = 1'b0;
        core_we        = 1'b0;
        sd_ack         = 1'b0;
        sd_buff_addr   = 9'd0;
        sd_buff_wr     = 1'b0;

        // Reset state
        #12;
        check("rst_lba", sd_lba, 32'd0);
        check("rst_rd_wr", {30'd0, sd_rd, sd_wr}, 32'd0);
        check("rst_flags", {28'd0, bk_ena, bk_reset, busy, dirty}, 32'd0);
        @(posedge clk_sys);
        #1;
        RESET_n = 1'b1;
        cycles(2);

        // 8192-byte image: full 16-sector load, probe buffer on sector 3
        img_size    = 32'd8192;
        img_mounted = 1'b1;
        for (int i = 0; i < 16; i++) serve(1'b0, i, i == 3, 1'b1, 1'b0);
        @(negedge clk_sys);
        check("load16_bk_reset", 32'(bk_reset), 32'd1);
        check("load16_busy", 32'(busy), 32'd0);
        check("load16_bk_ena", 32'(bk_ena), 32'd1);
        @(negedge clk_sys);
        check("load16_bk_reset_1cyc", 32'(bk_reset), 32'd0);

        // Core write marks dirty; save of 16 sectors clears it; buf_we blocked in SAVE
        @(posedge clk_sys);
        #1;
        core_we = 1'b1;
        cycles(1);
        core_we = 1'b0;
        @(negedge clk_sys);
        check("dirty_set", 32'(dirty), 32'd1);
        @(posedge clk_sys);
        #1;
        save_req = 1'b1;
        for (int i = 0; i < 16; i++) serve(1'b1, i, i == 3, 1'b0, 1'b0);
        @(negedge clk_sys);
        check("save16_dirty", 32'(dirty), 32'd0);
        check("save16_busy", 32'(busy), 32'd0);
        check("save16_no_bk_reset", 32'(bk_reset), 32'd0);

        // Remount 1000 bytes together with a save rise: load (2 sectors) runs, save dropped
        @(posedge clk_sys);
        #1;
        save_req    = 1'b0;
        img_mounted = 1'b0;
        cycles(2);
        img_size    = 32'd1000;
        img_mounted = 1'b1;
        save_req    = 1'b1;
        for (int i = 0; i < 2; i++) serve(1'b0, i, 1'b0, 1'b0, 1'b0);
        @(negedge clk_sys);
        check("load2_bk_reset", 32'(bk_reset), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            seen |= sd_wr | sd_rd | busy;
        end
        check("dropped_save_idle", 32'(seen), 32'd0);

        // Save clamps to 2 sectors; mid-save save_req rise ignored; core_we at completion wins
        @(posedge clk_sys);
        #1;
        save_req = 1'b0;
        cycles(1);
        save_req = 1'b1;
        serve(1'b1, 0, 1'b0, 1'b0, 1'b0);
        save_req = 1'b0;
        cycles(1);
        save_req = 1'b1;
        serve(1'b1, 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk_sys);
        check("save2_busy", 32'(busy), 32'd0);
        check("save2_dirty_set_wins", 32'(dirty), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            seen |= sd_wr | sd_rd;
        end
        check("save2_no_queued_save", 32'(seen), 32'd0);

        // Remount 8192 and abort at sector 7 with ack high
        @(posedge clk_sys);
        #1;
        save_req    = 1'b0;
        img_mounted = 1'b0;
        cycles(2);
        img_size    = 32'd8192;
        img_mounted = 1'b1;
        for (int i = 0; i < 7; i++) serve(1'b0, i, 1'b0, 1'b0, 1'b0);
        wait_req(ok);
        check("abort_lba", sd_lba, 32'd7);
        @(posedge clk_sys);
        #1;
        sd_ack = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("abort_rd", 32'(sd_rd), 32'd0);
        check("abort_bk_ena", 32'(bk_ena), 32'd0);
        check("abort_wait_ack", 32'(busy), 32'd1);
        @(posedge clk_sys);
        #1;
        sd_ack = 1'b0;
        seen = 1'b0;
        @(negedge clk_sys);
        seen |= bk_reset;
        @(negedge clk_sys);
        check("abort_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            seen |= bk_reset | sd_rd | sd_wr;
            @(negedge clk_sys);
        end
        check("abort_no_bk_reset", 32'(seen), 32'd0);

        // Async reset in the middle of a load
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        img_mounted    = 1'b0;
        cycles(2);
        img_mounted = 1'b1;
        wait_req(ok);
        check("pre_reset_rd", 32'(sd_rd), 32'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        check("async_rst_rd", 32'(sd_rd), 32'd0);
        check("async_rst_flags", {29'd0, bk_ena, busy, dirty}, 32'd0);
        cycles(2);
        RESET_n = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
